// File: rtl/vga_axil_regfile_if.sv
// Register-access bus between the AXI-Lite slave FSM (master) and the
// VGA register file (slave). Single-cycle read/write strobes; read data
// is registered by the register file.
interface vga_axil_regfile_if;
  typedef logic [31:0] axil_addr_t;
  typedef logic [31:0] axil_data_t;

  logic       write_en_i;
  axil_addr_t addr_write_i;
  axil_data_t wdata_i;
  logic       read_en_i;
  axil_addr_t addr_read_i;
  axil_data_t rdata_o;

  modport master (
    output write_en_i, addr_write_i, wdata_i, read_en_i, addr_read_i,
    input  rdata_o
  );

  modport slave (
    input  write_en_i, addr_write_i, wdata_i, read_en_i, addr_read_i,
    output rdata_o
  );
endinterface

// File: rtl/vga_axil_regfile.sv
// VGA controller register file. Software writes shadow registers; a COMMIT
// write arms a copy of all shadows into the active outputs at the next
// frame start, so the display never sees a half-updated configuration.
// Optional frame counter at 0x10 is built only when VGA_REGFILE_FRAME_CNT_EN
// is defined; otherwise that offset reads 0 and no counter flops exist.
module vga_axil_regfile (
  input  logic                clk,
  input  logic                arst_n,
  vga_axil_regfile_if.slave   bus,
  input  logic                frame_start_i,
  output logic                enable_o,
  output logic                test_pattern_o,
  output logic [11:0]         bg_color_o,
  output logic [31:0]         fb_base_o,
  output logic                irq_o
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_BG     = 3'd1;
  localparam logic [2:0] OFF_FB     = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_CNT    = 3'd4;
  localparam logic [2:0] OFF_COMMIT = 3'd5;

  logic [2:0]  wsel;
  logic [2:0]  rsel;
  logic        wr_ctrl, wr_bg, wr_fb, wr_status, wr_commit;

  logic [2:0]  sh_ctrl;
  logic [11:0] sh_bg;
  logic [29:0] sh_fb;

  logic        act_irq_en;
  logic [29:0] act_fb;

  logic        update_pending;
  logic        frame_irq;
  logic        commit_copy;
  logic [31:0] rd_mux;

  // Only addr[4:2] selects a register; the remaining address bits are
  // deliberately ignored (byte lanes and aliasing above 0x1C).
  logic        unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr_write_i[31:5], bus.addr_write_i[1:0],
                              bus.addr_read_i[31:5],  bus.addr_read_i[1:0]};

  assign wsel = bus.addr_write_i[4:2];
  assign rsel = bus.addr_read_i[4:2];

  assign wr_ctrl   = bus.write_en_i && (wsel == OFF_CTRL);
  assign wr_bg     = bus.write_en_i && (wsel == OFF_BG);
  assign wr_fb     = bus.write_en_i && (wsel == OFF_FB);
  assign wr_status = bus.write_en_i && (wsel == OFF_STATUS);
  assign wr_commit = bus.write_en_i && (wsel == OFF_COMMIT);

  // Copy uses the pending flag as it stood before this cycle, so a COMMIT
  // landing on the same frame start waits for the next one.
  assign commit_copy = frame_start_i && update_pending;

  // Shadow registers: software-visible configuration, no effect on outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sh_ctrl <= '0;
      sh_bg   <= '0;
      sh_fb   <= '0;
    end else begin
      if (wr_ctrl) sh_ctrl <= bus.wdata_i[2:0];
      if (wr_bg)   sh_bg   <= bus.wdata_i[11:0];
      if (wr_fb)   sh_fb   <= bus.wdata_i[31:2];
    end
  end

  // Active configuration: loaded from the pre-write shadow values on a
  // committed frame start.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      enable_o       <= 1'b0;
      test_pattern_o <= 1'b0;
      act_irq_en     <= 1'b0;
      bg_color_o     <= '0;
      act_fb         <= '0;
    end else if (commit_copy) begin
      enable_o       <= sh_ctrl[0];
      test_pattern_o <= sh_ctrl[1];
      act_irq_en     <= sh_ctrl[2];
      bg_color_o     <= sh_bg;
      act_fb         <= sh_fb;
    end
  end

  assign fb_base_o = {act_fb, 2'b00};

  // Commit arming: a COMMIT write always leaves the flag set, even when it
  // coincides with a copying frame start.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      update_pending <= 1'b0;
    end else if (wr_commit) begin
      update_pending <= 1'b1;
    end else if (commit_copy) begin
      update_pending <= 1'b0;
    end
  end

  // Frame interrupt flag: set by every frame start, W1C clear loses to set.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      frame_irq <= 1'b0;
    end else if (frame_start_i) begin
      frame_irq <= 1'b1;
    end else if (wr_status && bus.wdata_i[0]) begin
      frame_irq <= 1'b0;
    end
  end

  assign irq_o = frame_irq & act_irq_en;

`ifdef VGA_REGFILE_FRAME_CNT_EN
  logic [15:0] frame_cnt;

  // Free-running frame counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      frame_cnt <= '0;
    end else if (frame_start_i) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

  // Read decode from current register state (pre-write on a same-cycle write).
  always_comb begin
    rd_mux = '0;
    case (rsel)
      OFF_CTRL:   rd_mux = {29'd0, sh_ctrl};
      OFF_BG:     rd_mux = {20'd0, sh_bg};
      OFF_FB:     rd_mux = {sh_fb, 2'b00};
      OFF_STATUS: rd_mux = {30'd0, update_pending, frame_irq};
`ifdef VGA_REGFILE_FRAME_CNT_EN
      OFF_CNT:    rd_mux = {16'd0, frame_cnt};
`endif
      default:    rd_mux = '0;
    endcase
  end

  // Registered read data, held until the next read strobe.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bus.rdata_o <= '0;
    end else if (bus.read_en_i) begin
      bus.rdata_o <= rd_mux;
    end
  end

endmodule

// File: tb/tb_vga_axil_regfile.sv
// Directed self-checking bench for vga_axil_regfile. Works for both builds
// (with and without VGA_REGFILE_FRAME_CNT_EN).
module tb_vga_axil_regfile;
  logic        clk;
  logic        arst_n;
  logic        frame_start_i;
  logic        enable_o;
  logic        test_pattern_o;
  logic [11:0] bg_color_o;
  logic [31:0] fb_base_o;
  logic        irq_o;

  int errors = 0;
  int checks = 0;
  int frames_sent = 0;
  logic [31:0] rd;

  vga_axil_regfile_if bus();

  vga_axil_regfile dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .bus            (bus),
    .frame_start_i  (frame_start_i),
    .enable_o       (enable_o),
    .test_pattern_o (test_pattern_o),
    .bg_color_o     (bg_color_o),
    .fb_base_o      (fb_base_o),
    .irq_o          (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
    frames_sent++;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.write_en_i   = 1'b1;
    bus.addr_write_i = a;
    bus.wdata_i      = d;
    tick();
    bus.write_en_i   = 1'b0;
  endtask

  task automatic rdreg(input logic [31:0] a, output logic [31:0] d);
    bus.read_en_i   = 1'b1;
    bus.addr_read_i = a;
    tick();
    bus.read_en_i   = 1'b0;
    d = bus.rdata_o;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    tick();
    tick();
    arst_n = 1'b1;
    tick();
    frames_sent = 0;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    frame_start_i = 1'b0;
    bus.write_en_i = 1'b0;
    bus.read_en_i = 1'b0;
    bus.addr_write_i = '0;
    bus.addr_read_i = '0;
    bus.wdata_i = '0;
    tick();
    tick();
    checks++; if (enable_o !== 1'b0) begin errors++; $display("FAIL reset_enable got=%h exp=0", enable_o); end
    checks++; if (test_pattern_o !== 1'b0) begin errors++; $display("FAIL reset_tp got=%h exp=0", test_pattern_o); end
    checks++; if (bg_color_o !== 12'h0) begin errors++; $display("FAIL reset_bg got=%h exp=0", bg_color_o); end
    checks++; if (fb_base_o !== 32'h0) begin errors++; $display("FAIL reset_fb got=%h exp=0", fb_base_o); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got=%h exp=0", irq_o); end
    checks++; if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata_o); end
    arst_n = 1'b1;
    tick();
    frames_sent = 0;
    rdreg(32'h0C, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_status got=%h exp=0", rd); end
  endtask

  task automatic test_no_commit();
    wr(32'h00, 32'h7);
    wr(32'h04, 32'hABC);
    repeat (3) frame();
    checks++; if (enable_o !== 1'b0) begin errors++; $display("FAIL nocommit_enable got=%h exp=0", enable_o); end
    checks++; if (bg_color_o !== 12'h0) begin errors++; $display("FAIL nocommit_bg got=%h exp=0", bg_color_o); end
    rdreg(32'h0C, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL nocommit_status got=%h exp=1", rd); end
    rdreg(32'h04, rd);
    checks++; if (rd !== 32'hABC) begin errors++; $display("FAIL nocommit_bg_shadow got=%h exp=abc", rd); end
  endtask

  task automatic test_commit_fb();
    wr(32'h08, 32'h12345677);
    wr(32'h14, 32'hDEADBEEF);
    rdreg(32'h0C, rd);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL commit_pending_set got=%h exp=3", rd); end
    checks++; if (fb_base_o !== 32'h0) begin errors++; $display("FAIL commit_fb_before got=%h exp=0", fb_base_o); end
    frame();
    checks++; if (fb_base_o !== 32'h12345674) begin errors++; $display("FAIL commit_fb_active got=%h exp=12345674", fb_base_o); end
    checks++; if (enable_o !== 1'b1) begin errors++; $display("FAIL commit_enable got=%h exp=1", enable_o); end
    checks++; if (test_pattern_o !== 1'b1) begin errors++; $display("FAIL commit_tp got=%h exp=1", test_pattern_o); end
    checks++; if (bg_color_o !== 12'hABC) begin errors++; $display("FAIL commit_bg got=%h exp=abc", bg_color_o); end
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL commit_irq got=%h exp=1", irq_o); end
    rdreg(32'h0C, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL commit_pending_clr got=%h exp=1", rd); end
    rdreg(32'h08, rd);
    checks++; if (rd !== 32'h12345674) begin errors++; $display("FAIL commit_fb_read got=%h exp=12345674", rd); end
  endtask

  task automatic test_irq();
    wr(32'h00, 32'h4);
    wr(32'h14, 32'h0);
    frame();
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_set got=%h exp=1", irq_o); end
    checks++; if (enable_o !== 1'b0) begin errors++; $display("FAIL irq_enable_off got=%h exp=0", enable_o); end
    bus.write_en_i = 1'b1; bus.addr_write_i = 32'h0C; bus.wdata_i = 32'h1;
    frame_start_i = 1'b1;
    tick();
    bus.write_en_i = 1'b0; frame_start_i = 1'b0; frames_sent++;
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_set_wins got=%h exp=1", irq_o); end
    wr(32'h0C, 32'h1);
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_w1c got=%h exp=0", irq_o); end
    rdreg(32'h0C, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL irq_status got=%h exp=0", rd); end
  endtask

  task automatic test_shadow_race();
    wr(32'h04, 32'h222);
    wr(32'h14, 32'h0);
    bus.write_en_i = 1'b1; bus.addr_write_i = 32'h04; bus.wdata_i = 32'h111;
    frame_start_i = 1'b1;
    tick();
    bus.write_en_i = 1'b0; frame_start_i = 1'b0; frames_sent++;
    checks++; if (bg_color_o !== 12'h222) begin errors++; $display("FAIL race_bg_active got=%h exp=222", bg_color_o); end
    rdreg(32'h04, rd);
    checks++; if (rd !== 32'h111) begin errors++; $display("FAIL race_bg_shadow got=%h exp=111", rd); end
    rdreg(32'h0C, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL race_status got=%h exp=1", rd); end
  endtask

  task automatic test_commit_race();
    wr(32'h04, 32'h333);
    bus.write_en_i = 1'b1; bus.addr_write_i = 32'h14; bus.wdata_i = 32'h0;
    frame_start_i = 1'b1;
    tick();
    bus.write_en_i = 1'b0; frame_start_i = 1'b0; frames_sent++;
    checks++; if (bg_color_o !== 12'h222) begin errors++; $display("FAIL crace_nocopy got=%h exp=222", bg_color_o); end
    rdreg(32'h0C, rd);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL crace_pending got=%h exp=3", rd); end
    wr(32'h04, 32'h444);
    bus.write_en_i = 1'b1; bus.addr_write_i = 32'h14; bus.wdata_i = 32'h0;
    frame_start_i = 1'b1;
    tick();
    bus.write_en_i = 1'b0; frame_start_i = 1'b0; frames_sent++;
    checks++; if (bg_color_o !== 12'h444) begin errors++; $display("FAIL crace_copy got=%h exp=444", bg_color_o); end
    rdreg(32'h0C, rd);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL crace_pending_kept got=%h exp=3", rd); end
    frame();
    rdreg(32'h0C, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL crace_pending_clr got=%h exp=1", rd); end
  endtask

  task automatic test_back_to_back();
    bus.write_en_i = 1'b1; bus.addr_write_i = 32'h00; bus.wdata_i = 32'h1;
    bus.read_en_i = 1'b1;  bus.addr_read_i = 32'h00;
    tick();
    bus.write_en_i = 1'b0; bus.read_en_i = 1'b0;
    checks++; if (bus.rdata_o !== 32'h4) begin errors++; $display("FAIL rw_prewrite got=%h exp=4", bus.rdata_o); end
    repeat (3) tick();
    checks++; if (bus.rdata_o !== 32'h4) begin errors++; $display("FAIL rw_hold got=%h exp=4", bus.rdata_o); end
    rdreg(32'h00, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL rw_postwrite got=%h exp=1", rd); end
  endtask

  task automatic test_decode();
    logic [31:0] exp_cnt;
    wr(32'h20, 32'h2);
    rdreg(32'h00, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL dec_alias_wr got=%h exp=2", rd); end
    wr(32'h00, 32'h5);
    rdreg(32'h03, rd);
    checks++; if (rd !== 32'h5) begin errors++; $display("FAIL dec_low_bits got=%h exp=5", rd); end
    wr(32'h18, 32'hFFFFFFFF);
    wr(32'h1C, 32'hFFFFFFFF);
    rdreg(32'h18, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL dec_unmapped18 got=%h exp=0", rd); end
    rdreg(32'h1C, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL dec_unmapped1c got=%h exp=0", rd); end
    rdreg(32'h14, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL dec_commit_read got=%h exp=0", rd); end
    wr(32'h0C, 32'h2);
    rdreg(32'h0C, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL dec_status_ro got=%h exp=1", rd); end
    wr(32'h10, 32'hFFFF);
`ifdef VGA_REGFILE_FRAME_CNT_EN
    exp_cnt = frames_sent & 32'hFFFF;
`else
    exp_cnt = 32'h0;
`endif
    rdreg(32'h10, rd);
    checks++; if (rd !== exp_cnt) begin errors++; $display("FAIL dec_cnt_ro got=%h exp=%h", rd, exp_cnt); end
    checks++; if (enable_o !== 1'b0 || bg_color_o !== 12'h444) begin errors++; $display("FAIL dec_active_kept got=%h/%h exp=0/444", enable_o, bg_color_o); end
  endtask

  task automatic test_reset_mid();
    wr(32'h00, 32'h7);
    wr(32'h14, 32'h0);
    frame();
    rdreg(32'h00, rd);
    wr(32'h04, 32'h555);
    wr(32'h14, 32'h0);
    tick();
    #2 arst_n = 1'b0;
    #1;
    checks++; if (enable_o !== 1'b0) begin errors++; $display("FAIL rstmid_enable got=%h exp=0", enable_o); end
    checks++; if (fb_base_o !== 32'h0) begin errors++; $display("FAIL rstmid_fb got=%h exp=0", fb_base_o); end
    checks++; if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL rstmid_rdata got=%h exp=0", bus.rdata_o); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL rstmid_irq got=%h exp=0", irq_o); end
    @(posedge clk);
    #1 arst_n = 1'b1;
    frames_sent = 0;
    tick();
    frame();
    checks++; if (enable_o !== 1'b0 || test_pattern_o !== 1'b0) begin errors++; $display("FAIL rstpost_ctrl got=%h/%h exp=0/0", enable_o, test_pattern_o); end
    checks++; if (bg_color_o !== 12'h0) begin errors++; $display("FAIL rstpost_bg got=%h exp=0", bg_color_o); end
    checks++; if (fb_base_o !== 32'h0) begin errors++; $display("FAIL rstpost_fb got=%h exp=0", fb_base_o); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL rstpost_irq got=%h exp=0", irq_o); end
    rdreg(32'h0C, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL rstpost_status got=%h exp=1", rd); end
  endtask

  task automatic test_frame_cnt();
    do_reset();
`ifdef VGA_REGFILE_FRAME_CNT_EN
    frame_start_i = 1'b1;
    repeat (65537) tick();
    frame_start_i = 1'b0;
    rdreg(32'h10, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL framecnt_wrap got=%h exp=1", rd); end
`else
    repeat (5) frame();
    rdreg(32'h10, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL framecnt_absent got=%h exp=0", rd); end
`endif
  endtask

  initial begin
    test_reset();
    test_no_commit();
    test_commit_fb();
    test_irq();
    test_shadow_race();
    test_commit_race();
    test_back_to_back();
    test_decode();
    test_reset_mid();
    test_frame_cnt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_axil_regfile.md
VGA_AXIL_REGFILE -- requirements
Module: vga_axil_regfile

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port arst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port write_en_i, input, 1, single-cycle write strobe from the AXI-Lite slave FSM.
REQ-004 SHALL have port addr_write_i, input, axil_addr_t, write byte address.
REQ-005 SHALL have port wdata_i, input, axil_data_t (32), write data.
REQ-006 SHALL have port read_en_i, input, 1, single-cycle read strobe from the AXI-Lite slave FSM.
REQ-007 SHALL have port addr_read_i, input, axil_addr_t, read byte address.
REQ-008 SHALL have port rdata_o, output, axil_data_t (32), read data, drives the FSM data_i.
REQ-009 SHALL have port frame_start_i, input, 1, one-cycle pulse from VGA timing at the start of each frame.
REQ-010 SHALL have ports enable_o (1), test_pattern_o (1), bg_color_o (12, RGB444), fb_base_o (32), all outputs, active configuration.
REQ-011 SHALL have port irq_o, output, 1, level frame interrupt.

Function
REQ-012 SHALL decode addr[4:2]; addr[1:0] and bits above 4 ignored.
REQ-013 SHALL map: 0x00 CTRL RW shadow (bit0 enable, bit1 test_pattern, bit2 irq_en); 0x04 BG_COLOR RW shadow [11:0]; 0x08 FB_BASE RW shadow, bits[1:0] read 0 and never stored; 0x0C STATUS (bit0 frame_irq W1C, bit1 update_pending RO); 0x10 FRAME_CNT RO [15:0]; 0x14 COMMIT WO (reads 0).
REQ-014 SHALL return 0 for reads of unmapped offsets 0x18/0x1C and ignore writes to them and to RO fields.
REQ-015 SHALL register read data: rdata_o valid the cycle after read_en_i and held until the next read_en_i.
REQ-016 SHALL, on simultaneous read and write of the same register, return the pre-write value.
REQ-017 SHALL update shadow registers the cycle after write_en_i; active outputs are unaffected by shadow writes.
REQ-018 SHALL set update_pending on any COMMIT write (data ignored).
REQ-019 SHALL, on frame_start_i with update_pending=1, copy all shadows to active outputs (visible next cycle) and clear update_pending.
REQ-020 SHALL, when COMMIT write and frame_start_i coincide, apply no copy in that cycle unless update_pending was already 1; update_pending ends at 1.
REQ-021 SHALL, when a shadow write and a copying frame_start_i coincide, copy the old shadow value; the new value reaches active only on a later commit.
REQ-022 SHALL set frame_irq on every frame_start_i; W1C of bit0 clears it; set wins over simultaneous clear.
REQ-023 SHALL drive irq_o = frame_irq AND active irq_en, combinationally from registers.
REQ-024 SHALL increment FRAME_CNT on every frame_start_i, wrapping 0xFFFF -> 0x0000.

Reset
REQ-025 SHALL, on arst_n low, clear all shadows, active outputs, update_pending, frame_irq, FRAME_CNT and rdata_o to 0 immediately.
REQ-026 SHALL drop any pending commit when reset asserts mid-frame; after release, behaviour is as from power-up.

Configuration
REQ-027 SHALL compile FRAME_CNT when VGA_REGFILE_FRAME_CNT_EN is defined; without it, offset 0x10 reads 0, no counter flops exist, all else unchanged.

Verification
REQ-028 Write CTRL=0x7, BG=0xABC, no commit, 3 frame_start_i -> enable_o=0, bg_color_o=0, STATUS=0x1.
REQ-029 Write FB_BASE=0x12345677, COMMIT, frame_start_i -> update_pending 1 then 0; fb_base_o=0x12345674; FB_BASE read=0x12345674.
REQ-030 CTRL=0x4 committed, frame_start_i -> irq_o=1; W1C 0x1 on same cycle as next frame_start_i -> irq_o stays 1; W1C alone -> irq_o=0.
REQ-031 Update_pending=1, write BG=0x111 coinciding with frame_start_i -> bg_color_o=old shadow; BG read=0x111; update_pending=0.
REQ-032 With VGA_REGFILE_FRAME_CNT_EN, 65537 frame_start_i -> FRAME_CNT=0x0001; without macro -> 0x0000.
REQ-033 Commit pending, assert arst_n low 1 cycle mid-frame, then frame_start_i -> all outputs 0, STATUS=0x1.
